// File: rtl/kf_pic_pkg.sv
// Shared types and helpers for the KF PIC sequencer: FSM encoding, poll-word layout,
// channel rotation and one-hot encoding for up to 32 channels.
// No ports; the functions are purely combinational.
package kf_pic_pkg;

  localparam int KF_PIC_MAX_IRQ = 32;

  // The poll-word valid flag sits this many bits below the top of the returned word,
  // i.e. it is the MSB of control_logic_data.
  localparam int POLL_VLD_OFFSET = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACK1  = 3'd1,
    ST_ACK2W = 3'd2,
    ST_ACK2  = 3'd3,
    ST_POLL  = 3'd4
  } kf_pic_state_e;

  // Rotate the low n bits of v left by amt (n is a power of two, 8..32).
  function automatic logic [31:0] rotate_left(input logic [31:0] v, input logic [4:0] amt,
                                              input int unsigned n);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n) r[5'((i + 32'(amt)) & (n - 1))] = v[5'(i)];
    end
    return r;
  endfunction

  // Index of the set bit in a one-hot vector (zero when empty).
  function automatic logic [4:0] onehot_to_id(input logic [31:0] oh);
    logic [4:0] id;
    id = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) id = id | 5'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/kf_pic_sequencer_if.sv
// Bus-decode side of the sequencer: mask/EOI/poll command strobes in, vector/poll word out.
// master = bus-interface decode, slave = sequencer core.
// Strobes are single-cycle; the data return has no backpressure.
interface kf_pic_sequencer_if #(
  parameter int NUM_IRQ      = 8,
  parameter int VECTOR_WIDTH = 8
);
  localparam int ID_WIDTH = $clog2(NUM_IRQ);

  logic                    write_mask;
  logic [NUM_IRQ-1:0]      mask_data;
  logic                    write_eoi;
  logic                    eoi_specific;
  logic [ID_WIDTH-1:0]     eoi_level;
  logic                    poll_read;
  logic                    out_control_logic_data;
  logic [VECTOR_WIDTH-1:0] control_logic_data;

  modport master (
    output write_mask, mask_data, write_eoi, eoi_specific, eoi_level, poll_read,
    input  out_control_logic_data, control_logic_data
  );

  modport slave (
    input  write_mask, mask_data, write_eoi, eoi_specific, eoi_level, poll_read,
    output out_control_logic_data, control_logic_data
  );
endinterface

// File: rtl/kf_pic_priority_resolver.sv
// Rotating-priority resolver: picks the highest-priority pending channel and checks it
// outranks the highest in-service channel (fully nested). Purely combinational, 0 cycles.
// Ports: pending_i/isr_i/rotate_base_i in; winner_vld_o/winner_id_o, isr_vld_o/isr_id_o out.
module kf_pic_priority_resolver
  import kf_pic_pkg::*;
#(
  parameter  int NUM_IRQ  = 8,
  localparam int ID_WIDTH = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0]  pending_i,
  input  logic [NUM_IRQ-1:0]  isr_i,
  input  logic [ID_WIDTH-1:0] rotate_base_i,
  output logic                winner_vld_o,
  output logic [ID_WIDTH-1:0] winner_id_o,
  output logic                isr_vld_o,
  output logic [ID_WIDTH-1:0] isr_id_o
);

  logic [31:0]         pend_ext, isr_ext, pend_rot, isr_rot, pend_lsb, isr_lsb;
  logic [ID_WIDTH-1:0] neg_base;
  logic [4:0]          rot_amt, pend_pos, isr_pos;

  always_comb begin
    pend_ext = '0;
    isr_ext  = '0;
    pend_ext[NUM_IRQ-1:0] = pending_i;
    isr_ext[NUM_IRQ-1:0]  = isr_i;

    // Rotate so that rotate_base lands on bit 0; bit position then equals priority rank.
    neg_base = '0 - rotate_base_i;
    rot_amt  = '0;
    rot_amt[ID_WIDTH-1:0] = neg_base;

    pend_rot = rotate_left(pend_ext, rot_amt, NUM_IRQ);
    isr_rot  = rotate_left(isr_ext, rot_amt, NUM_IRQ);
    pend_lsb = pend_rot & (~pend_rot + 32'd1);
    isr_lsb  = isr_rot & (~isr_rot + 32'd1);
    pend_pos = onehot_to_id(pend_lsb);
    isr_pos  = onehot_to_id(isr_lsb);

    winner_vld_o = (|pend_rot) && (!(|isr_rot) || (pend_pos < isr_pos));
    isr_vld_o    = |isr_rot;
    // Rank back to channel id; power-of-two width makes the add wrap modulo NUM_IRQ.
    winner_id_o  = pend_pos[ID_WIDTH-1:0] + rotate_base_i;
    isr_id_o     = isr_pos[ID_WIDTH-1:0] + rotate_base_i;
  end

endmodule

// File: rtl/kf_pic_sequencer.sv
// Interrupt sequencer: IRR/IMR/ISR state, fully-nested priority, two-pulse INTA and poll,
// encoded vector return. Vector valid from the first ACK2 cycle; poll word one cycle after poll_read.
// No backpressure: strobes act in the cycle seen. Optional KF_PIC_AUTO_ROTATE_EN enables rotation.
// Ports: clock/reset_n; interrupt_request, config inputs, vector_base, interrupt_acknowledge_n in;
// interrupt_to_cpu, in_service, interrupt_mask out; command strobes and data return on bus.
module kf_pic_sequencer
  import kf_pic_pkg::*;
#(
  parameter  int NUM_IRQ      = 8,
  parameter  int VECTOR_WIDTH = 8,
  localparam int ID_WIDTH     = $clog2(NUM_IRQ)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_IRQ-1:0]               interrupt_request,
  input  logic                             level_triggered_config,
  input  logic                             auto_eoi_config,
  input  logic [VECTOR_WIDTH-ID_WIDTH-1:0] vector_base,
  input  logic                             interrupt_acknowledge_n,
  output logic                             interrupt_to_cpu,
  output logic [NUM_IRQ-1:0]               in_service,
  output logic [NUM_IRQ-1:0]               interrupt_mask,
  kf_pic_sequencer_if.slave                bus
);

  kf_pic_state_e       state_q, state_d;
  logic                inta_q;
  logic [NUM_IRQ-1:0]  irq_q;
  logic [NUM_IRQ-1:0]  irr_q, irr_d, irr_clr;
  logic [NUM_IRQ-1:0]  isr_q, isr_d;
  logic [NUM_IRQ-1:0]  imr_q, imr_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic                spurious_q, spurious_d;
  logic [ID_WIDTH-1:0] rotate_base;

  logic                winner_vld, isr_vld;
  logic [ID_WIDTH-1:0] winner_id, isr_id;
  logic                inta_fall, inta_rise, end_of_ack, eoi_ns, ack_drive;
  logic [VECTOR_WIDTH-1:0] poll_word;

  assign inta_fall  = inta_q & ~interrupt_acknowledge_n;
  assign inta_rise  = ~inta_q & interrupt_acknowledge_n;
  assign end_of_ack = (state_q == ST_ACK2) && inta_rise;
  assign eoi_ns     = bus.write_eoi && !bus.eoi_specific && isr_vld;

  kf_pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_resolver (
    .pending_i     (irr_q & ~imr_q),
    .isr_i         (isr_q),
    .rotate_base_i (rotate_base),
    .winner_vld_o  (winner_vld),
    .winner_id_o   (winner_id),
    .isr_vld_o     (isr_vld),
    .isr_id_o      (isr_id)
  );

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    spurious_d = spurious_q;
    isr_d      = isr_q;
    irr_clr    = '0;

    if (bus.write_eoi) begin
      if (bus.eoi_specific) isr_d[bus.eoi_level] = 1'b0;
      else if (isr_vld)     isr_d[isr_id]        = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (inta_fall || bus.poll_read) begin
          // INTA takes precedence over a coincident poll.
          state_d = inta_fall ? ST_ACK1 : ST_POLL;
          if (winner_vld) begin
            isr_d[winner_id]   = 1'b1;
            irr_clr[winner_id] = 1'b1;
            id_d               = winner_id;
            spurious_d         = 1'b0;
          end else begin
            id_d       = ID_WIDTH'(NUM_IRQ - 1);
            spurious_d = 1'b1;
          end
        end
      end
      ST_ACK1:  if (inta_rise) state_d = ST_ACK2W;
      ST_ACK2W: if (inta_fall) state_d = ST_ACK2;
      ST_ACK2: begin
        if (end_of_ack) begin
          state_d = ST_IDLE;
          if (auto_eoi_config && !spurious_q) isr_d[id_q] = 1'b0;
        end
      end
      ST_POLL:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Edge mode: set on a rising IR edge, with set winning over a same-cycle latch clear.
  assign irr_d = level_triggered_config ? interrupt_request
                                        : ((irr_q & ~irr_clr) | (interrupt_request & ~irq_q));
  assign imr_d = bus.write_mask ? bus.mask_data : imr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      inta_q     <= 1'b1;
      irq_q      <= '0;
      irr_q      <= '0;
      isr_q      <= '0;
      imr_q      <= '0;
      id_q       <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inta_q     <= interrupt_acknowledge_n;
      irq_q      <= interrupt_request;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      imr_q      <= imr_d;
      id_q       <= id_d;
      spurious_q <= spurious_d;
    end
  end

`ifdef KF_PIC_AUTO_ROTATE_EN
  logic [ID_WIDTH-1:0] rotate_base_q, rotate_base_d;

  // A completed ack outranks a same-cycle EOI for the new base; spurious acks never rotate.
  always_comb begin
    rotate_base_d = rotate_base_q;
    if (eoi_ns)                    rotate_base_d = isr_id + ID_WIDTH'(1);
    if (end_of_ack && !spurious_q) rotate_base_d = id_q + ID_WIDTH'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rotate_base_q <= '0;
    else          rotate_base_q <= rotate_base_d;
  end

  assign rotate_base = rotate_base_q;
`else
  assign rotate_base = '0;
`endif

  always_comb begin
    poll_word = '0;
    if (!spurious_q) begin
      poll_word[ID_WIDTH-1:0]                  = id_q;
      poll_word[VECTOR_WIDTH-POLL_VLD_OFFSET]  = 1'b1;
    end
  end

  assign ack_drive        = (state_q == ST_ACK2) && !interrupt_acknowledge_n;
  assign interrupt_to_cpu = (state_q == ST_IDLE) && winner_vld;
  assign in_service       = isr_q;
  assign interrupt_mask   = imr_q;

  assign bus.out_control_logic_data = ack_drive || (state_q == ST_POLL);
  assign bus.control_logic_data     = ack_drive              ? {vector_base, id_q} :
                                      (state_q == ST_POLL)   ? poll_word : '0;

endmodule

// File: tb/tb_kf_pic_sequencer.sv
// Self-checking bench for kf_pic_sequencer (NUM_IRQ=8, VECTOR_WIDTH=8, vector_base=5'h08).
// Returned vectors/poll words are queued as expected when the INTA or poll is driven and
// compared when the sequencer drives its data enable.
module tb_kf_pic_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] interrupt_request;
  logic       level_triggered_config;
  logic       auto_eoi_config;
  logic [4:0] vector_base;
  logic       interrupt_acknowledge_n;
  logic       interrupt_to_cpu;
  logic [7:0] in_service;
  logic [7:0] interrupt_mask;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

`ifdef KF_PIC_AUTO_ROTATE_EN
  localparam int T3_FIRST = 2, T3_SECOND = 0, T4_FIRST = 7, T4_SECOND = 0;
`else
  localparam int T3_FIRST = 0, T3_SECOND = 2, T4_FIRST = 0, T4_SECOND = 7;
`endif

  kf_pic_sequencer_if #(.NUM_IRQ(8), .VECTOR_WIDTH(8)) bus ();

  kf_pic_sequencer #(.NUM_IRQ(8), .VECTOR_WIDTH(8)) dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .interrupt_request       (interrupt_request),
    .level_triggered_config  (level_triggered_config),
    .auto_eoi_config         (auto_eoi_config),
    .vector_base             (vector_base),
    .interrupt_acknowledge_n (interrupt_acknowledge_n),
    .interrupt_to_cpu        (interrupt_to_cpu),
    .in_service              (in_service),
    .interrupt_mask          (interrupt_mask),
    .bus                     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every cycle the data enable is up, pop one expected word and compare.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && bus.out_control_logic_data === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_drive", 32'(bus.out_control_logic_data), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("data_word", 32'(bus.control_logic_data), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    interrupt_request = '0;
    interrupt_acknowledge_n = 1'b1;
    bus.write_mask = 1'b0;
    bus.write_eoi  = 1'b0;
    bus.poll_read  = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic raise_ir(input logic [7:0] bits);
    interrupt_request = interrupt_request | bits;
    tick(1);
    interrupt_request = interrupt_request & ~bits;
    tick(1);
  endtask

  task automatic ack_first_half();
    interrupt_acknowledge_n = 1'b0;
    tick(2);
    interrupt_acknowledge_n = 1'b1;
    tick(2);
  endtask

  task automatic ack_second_half();
    interrupt_acknowledge_n = 1'b0;
    tick(2);
    interrupt_acknowledge_n = 1'b1;
    tick(2);
    check("sb_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic ack_pair(input logic [7:0] exp_vec);
    exp_q.push_back(exp_vec);
    ack_first_half();
    ack_second_half();
  endtask

  task automatic do_poll(input logic [7:0] exp_word);
    exp_q.push_back(exp_word);
    bus.poll_read = 1'b1;
    tick(1);
    bus.poll_read = 1'b0;
    tick(2);
    check("sb_poll", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic eoi(input logic specific, input logic [2:0] lvl);
    bus.write_eoi    = 1'b1;
    bus.eoi_specific = specific;
    bus.eoi_level    = lvl;
    tick(1);
    bus.write_eoi = 1'b0;
    tick(1);
  endtask

  task automatic set_mask(input logic [7:0] m);
    bus.write_mask = 1'b1;
    bus.mask_data  = m;
    tick(1);
    bus.write_mask = 1'b0;
    tick(1);
  endtask

  initial begin
    interrupt_request       = '0;
    level_triggered_config  = 1'b0;
    auto_eoi_config         = 1'b0;
    vector_base             = 5'h08;
    interrupt_acknowledge_n = 1'b1;
    bus.write_mask   = 1'b0;
    bus.mask_data    = '0;
    bus.write_eoi    = 1'b0;
    bus.eoi_specific = 1'b0;
    bus.eoi_level    = '0;
    bus.poll_read    = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst_int",  32'(interrupt_to_cpu), 32'd0);
    check("rst_isr",  32'(in_service), 32'd0);
    check("rst_imr",  32'(interrupt_mask), 32'd0);
    check("rst_oe",   32'(bus.out_control_logic_data), 32'd0);
    check("rst_data", 32'(bus.control_logic_data), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // Basic edge-triggered ack of IR3.
    raise_ir(8'h08);
    check("t1_int", 32'(interrupt_to_cpu), 32'd1);
    exp_q.push_back(8'h43);
    ack_first_half();
    check("t1_isr_ack1", 32'(in_service), 32'h08);
    check("t1_int_busy", 32'(interrupt_to_cpu), 32'd0);
    ack_second_half();
    check("t1_isr_end", 32'(in_service), 32'h08);
    eoi(1'b0, 3'd0);
    check("t1_isr_eoi", 32'(in_service), 32'h00);

    // Masking, and a masked channel stays in service.
    do_reset();
    set_mask(8'h08);
    check("mask_imr", 32'(interrupt_mask), 32'h08);
    raise_ir(8'h08);
    check("mask_int_off", 32'(interrupt_to_cpu), 32'd0);
    set_mask(8'h00);
    check("mask_int_on", 32'(interrupt_to_cpu), 32'd1);
    ack_pair(8'h43);
    set_mask(8'h08);
    check("mask_isr_kept", 32'(in_service), 32'h08);
    eoi(1'b1, 3'd3);
    check("mask_isr_seoi", 32'(in_service), 32'h00);
    set_mask(8'h00);

`ifndef KF_PIC_AUTO_ROTATE_EN
    // Fully nested: IR2 preempts IR5, IR6 waits.
    do_reset();
    raise_ir(8'h20);
    ack_pair(8'h45);
    check("t2_isr5", 32'(in_service), 32'h20);
    raise_ir(8'h44);
    check("t2_int_ir2", 32'(interrupt_to_cpu), 32'd1);
    ack_pair(8'h42);
    check("t2_isr25", 32'(in_service), 32'h24);
    check("t2_ir6_blocked", 32'(interrupt_to_cpu), 32'd0);
    eoi(1'b0, 3'd0);
    check("t2_eoi_bit2", 32'(in_service), 32'h20);
    check("t2_ir6_still", 32'(interrupt_to_cpu), 32'd0);
    eoi(1'b0, 3'd0);
    check("t2_eoi_bit5", 32'(in_service), 32'h00);
    check("t2_ir6_now", 32'(interrupt_to_cpu), 32'd1);
    ack_pair(8'h46);
    eoi(1'b1, 3'd6);
    check("t2_clean", 32'(in_service), 32'h00);
`endif

    // Priority order with IR0 and IR2 (rotated after IR1 when rotation is built in).
    do_reset();
`ifdef KF_PIC_AUTO_ROTATE_EN
    raise_ir(8'h02);
    ack_pair(8'h41);
    eoi(1'b0, 3'd0);
    check("t3_ir1_clear", 32'(in_service), 32'h00);
`endif
    raise_ir(8'h05);
    ack_pair(8'h40 | 8'(T3_FIRST));
    check("t3_first_isr", 32'(in_service), 32'(1 << T3_FIRST));
    eoi(1'b0, 3'd0);
    ack_pair(8'h40 | 8'(T3_SECOND));
    check("t3_second_isr", 32'(in_service), 32'(1 << T3_SECOND));
    eoi(1'b0, 3'd0);

    // Spurious ack: id 7, no ISR bit, no rotation.
    check("t4_idle_int", 32'(interrupt_to_cpu), 32'd0);
    ack_pair(8'h47);
    check("t4_isr_none", 32'(in_service), 32'h00);
    raise_ir(8'h81);
    ack_pair(8'h40 | 8'(T4_FIRST));
    check("t4_first_isr", 32'(in_service), 32'(1 << T4_FIRST));
    eoi(1'b0, 3'd0);
    ack_pair(8'h40 | 8'(T4_SECOND));
    eoi(1'b0, 3'd0);
    check("t4_clean", 32'(in_service), 32'h00);

    // Auto-EOI clears the ISR bit at end of ack.
    do_reset();
    auto_eoi_config = 1'b1;
    raise_ir(8'h08);
    ack_pair(8'h43);
    check("aeoi_isr", 32'(in_service), 32'h00);
    auto_eoi_config = 1'b0;

    // Level mode follows the line.
    do_reset();
    level_triggered_config = 1'b1;
    interrupt_request = 8'h02;
    tick(1);
    check("lvl_int_high", 32'(interrupt_to_cpu), 32'd1);
    interrupt_request = 8'h00;
    tick(1);
    check("lvl_int_low", 32'(interrupt_to_cpu), 32'd0);
    level_triggered_config = 1'b0;

    // Poll: valid word with id 4, ISR set; then empty poll returns zero.
    do_reset();
    raise_ir(8'h10);
    do_poll(8'h84);
    check("poll_isr", 32'(in_service), 32'h10);
    eoi(1'b0, 3'd0);
    do_poll(8'h00);
    check("poll_empty_isr", 32'(in_service), 32'h00);

    // Reset in ACK2W aborts everything; next INTA starts from IDLE.
    do_reset();
    raise_ir(8'h10);
    ack_first_half();
    check("rst2_isr_pre", 32'(in_service), 32'h10);
    reset_n = 1'b0;
    #2;
    check("rst2_isr",  32'(in_service), 32'h00);
    check("rst2_int",  32'(interrupt_to_cpu), 32'd0);
    check("rst2_oe",   32'(bus.out_control_logic_data), 32'd0);
    check("rst2_data", 32'(bus.control_logic_data), 32'd0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    ack_pair(8'h47);
    check("rst2_after_isr", 32'(in_service), 32'h00);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
